id_ex_stage: RTL
================

# id_ex_stage

Decode-and-issue pipeline stage directly upstream of the RV32I ALU. It accepts one fetched instruction per handshake, with its register-file read data, and decodes it into the ALU control set (`func`, `sub_sra`, `shamt`) plus operands A/B. It applies a one-entry writeback bypass, then holds the result in a valid/ready output register that feeds the ALU and the EX-stage bookkeeping (rd, write enable, branch type).

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  instruction and operands present.
- `in_ready`  out  1  stage can accept; equals `!out_valid || out_ready`.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  32  instruction address.
- `rs1_data`, `rs2_data`  in  32 each  register-file read data for `in_instr[19:15]` and `in_instr[24:20]`.
- `wb_we`  in  1  writeback bypass valid.
- `wb_rd`  in  5  writeback bypass destination register.
- `wb_data`  in  32  writeback bypass value.
- `flush`  in  1  kill the held and incoming instruction.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  ALU/EX accepts the bundle.
- `out_a`, `out_b`  out  32 each  ALU operands.
- `out_shamt`  out  5  ALU immediate shift amount.
- `out_sub_sra`  out  1  selects subtract or arithmetic right shift.
- `out_func`  out  4  ALU function code.
- `out_rd`  out  5  destination register.
- `out_we`  out  1  register write enable.
- `out_br`  out  3  branch condition, `funct3` of the branch; `out_is_br` marks a branch.
- `out_is_br`  out  1  bundle is a branch.
- `out_pc`  out  32  PC of the bundle.
- `out_illegal`  out  1  unsupported opcode or funct.

## Operation
- ALU func codes (must match the ALU):
  - 0 ADD/SUB; 1 XOR; 2 OR; 3 AND
  - 4 SLLI; 5 SLL; 6 SRL/SRA; 7 SRLI/SRAI
  - 8 SLT; 9 SLTU
- Operand A and B per opcode:
  - OP (0110011): A=rs1, B=rs2.
    - For SLL/SRL/SRA, B is `{27'b0, rs2[4:0]}`, because the ALU shifts by the full B.
    - `sub_sra`=instr[30] for ADD/SUB and SRL/SRA; 0 otherwise.
  - OP-IMM (0010011): A=rs1, B=sign-extended I-immediate; `shamt`=instr[24:20].
    - SLLI/SRLI/SRAI use func 4/7; `sub_sra`=instr[30] only for SRxI.
  - LUI: A=0, B=U-immediate, func 0.
  - AUIPC: A=pc, B=U-immediate, func 0.
  - BRANCH (1100011): A=rs1, B=rs2, func 0, `sub_sra`=1 (subtract), `out_is_br`=1, `out_we`=0.
- `out_we`=1 for OP, OP-IMM, LUI and AUIPC when rd≠0; otherwise 0.
- Illegal cases:
  - Any other opcode, OP with funct7 ∉ {0000000, 0100000}, or funct7 0100000 on a funct3 other than ADD or SR.
  - SLLI/SRxI with a bad funct7.
  - An illegal bundle is issued with `out_illegal`=1, `out_we`=0 and func 0.
- Bypass: if `wb_we` && `wb_rd`≠0 && `wb_rd`==rs1 (resp. rs2), use `wb_data` instead of the register-file data. The bypass applies before the shift masking.
- Output register load: when `in_valid && in_ready && !flush`; `out_valid` is set to 1.
- When `out_ready` is asserted with no new load, `out_valid` goes to 0.
- Under stall (`out_valid && !out_ready`), all outputs hold stable.

## Timing
- Latency is 1 cycle, input handshake to `out_valid`. Throughput is 1 per cycle when `out_ready` is held high.
- `in_ready` is combinational from `out_valid`/`out_ready`; there is no path from `in_valid`.
- `flush` has priority over load and hold: `out_valid`←0 on the next edge, and an incoming instruction that cycle is dropped.
- Simultaneous output consume and input load: the new bundle replaces the old with no bubble.
- Reset, at any time including mid-stall: `out_valid`=0 and every data output is 0. `in_ready` is therefore 1 while in reset.
- Decode is combinational on the inputs; only the output bundle is registered.

## Structure
- Shared package `rv32i_pkg`:
  - opcode constants
  - ALU func code constants (0–9)
  - the bundle struct `ex_bundle_t` {a, b, shamt, sub_sra, func, rd, we, br, is_br, pc, illegal}
- Sub-module `rv32i_decoder`, purely combinational: instr, pc, rs1, rs2 → `ex_bundle_t`.
- The top level holds the bypass muxes, the handshake and the output register.

## Test plan
- Issue `add x3,x1,x2` with rs1=5, rs2=7 and out_ready=1 → next cycle out_valid=1, a=5, b=7, func=0, sub_sra=0, rd=3, we=1.
- Issue `sra x4,x1,x2` with rs2=0xFFFF_FFE3 → b=0x0000_0003, func=6, sub_sra=1. Then `srai x4,x1,9` → func=7, shamt=9, sub_sra=1.
- Issue `addi x5,x0,-1` with wb_we=1, wb_rd=0, wb_data=0x55 → a=0, b=0xFFFF_FFFF. Repeat with rs1=x6 and wb_rd=6 → a=0x55.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and the outputs stay unchanged. Release → the next instruction appears the following cycle and nothing is lost or duplicated.
- Assert flush together with in_valid while a bundle is held → out_valid=0 on the next edge. The incoming instruction never appears.
- Issue opcode 0x7F → out_illegal=1, we=0. Drop rst_n mid-stall → out_valid=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared RV32I constants (opcodes, ALU function codes) and the
//               decoded EX-stage bundle type.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

  // Major opcodes handled by the issue stage
  localparam logic [6:0] c_opc_op     = 7'b0110011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;

  // ALU function codes; these must track the ALU's own decode
  localparam logic [3:0] c_func_add  = 4'd0;
  localparam logic [3:0] c_func_xor  = 4'd1;
  localparam logic [3:0] c_func_or   = 4'd2;
  localparam logic [3:0] c_func_and  = 4'd3;
  localparam logic [3:0] c_func_slli = 4'd4;
  localparam logic [3:0] c_func_sll  = 4'd5;
  localparam logic [3:0] c_func_sr   = 4'd6;
  localparam logic [3:0] c_func_sri  = 4'd7;
  localparam logic [3:0] c_func_slt  = 4'd8;
  localparam logic [3:0] c_func_sltu = 4'd9;

  // funct7 encodings accepted on OP / shift-immediate instructions
  localparam logic [6:0] c_f7_base = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;

  // Decoded bundle handed to the ALU and EX bookkeeping
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        sub_sra;
    logic [3:0]  func;
    logic [4:0]  rd;
    logic        we;
    logic [2:0]  br;
    logic        is_br;
    logic [31:0] pc;
    logic        illegal;
  } ex_bundle_t;

endpackage
`default_nettype wire

// File: rtl/rv32i_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_decoder
// Description : Purely combinational RV32I integer decoder producing the ALU
//               control set, operands and EX bookkeeping for one instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_decoder
  import rv32i_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output ex_bundle_t  o_bundle
);

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic        w_illegal;
  logic        w_we;

  assign w_opcode = i_instr[6:0];
  assign w_rd     = i_instr[11:7];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_u  = {i_instr[31:12], 12'b0};

  // Decode opcode/funct fields into operands and ALU controls; illegal
  // encodings are forced to a harmless func 0 with no register write.
  always_comb begin
    o_bundle    = '0;
    w_illegal   = 1'b0;
    w_we        = 1'b0;
    o_bundle.rd = w_rd;
    o_bundle.pc = i_pc;
    case (w_opcode)
      c_opc_op: begin
        o_bundle.a = i_rs1;
        o_bundle.b = i_rs2;
        w_we       = 1'b1;
        case (w_funct3)
          3'b000: begin
            o_bundle.func    = c_func_add;
            o_bundle.sub_sra = i_instr[30];
          end
          3'b001: begin
            // ALU shifts by the whole B operand, so keep only rs2[4:0]
            o_bundle.func = c_func_sll;
            o_bundle.b    = {27'b0, i_rs2[4:0]};
          end
          3'b010:  o_bundle.func = c_func_slt;
          3'b011:  o_bundle.func = c_func_sltu;
          3'b100:  o_bundle.func = c_func_xor;
          3'b101: begin
            o_bundle.func    = c_func_sr;
            o_bundle.b       = {27'b0, i_rs2[4:0]};
            o_bundle.sub_sra = i_instr[30];
          end
          3'b110:  o_bundle.func = c_func_or;
          default: o_bundle.func = c_func_and;
        endcase
        if (w_funct7 == c_f7_alt) begin
          w_illegal = !((w_funct3 == 3'b000) || (w_funct3 == 3'b101));
        end else begin
          w_illegal = (w_funct7 != c_f7_base);
        end
      end
      c_opc_op_imm: begin
        o_bundle.a     = i_rs1;
        o_bundle.b     = w_imm_i;
        o_bundle.shamt = i_instr[24:20];
        w_we           = 1'b1;
        case (w_funct3)
          3'b000:  o_bundle.func = c_func_add;
          3'b001: begin
            o_bundle.func = c_func_slli;
            w_illegal     = (w_funct7 != c_f7_base);
          end
          3'b010:  o_bundle.func = c_func_slt;
          3'b011:  o_bundle.func = c_func_sltu;
          3'b100:  o_bundle.func = c_func_xor;
          3'b101: begin
            o_bundle.func    = c_func_sri;
            o_bundle.sub_sra = i_instr[30];
            w_illegal        = !((w_funct7 == c_f7_base) || (w_funct7 == c_f7_alt));
          end
          3'b110:  o_bundle.func = c_func_or;
          default: o_bundle.func = c_func_and;
        endcase
      end
      c_opc_lui: begin
        o_bundle.b = w_imm_u;
        w_we       = 1'b1;
      end
      c_opc_auipc: begin
        o_bundle.a = i_pc;
        o_bundle.b = w_imm_u;
        w_we       = 1'b1;
      end
      c_opc_branch: begin
        // Branch compare is done as rs1 - rs2 in the ALU
        o_bundle.a       = i_rs1;
        o_bundle.b       = i_rs2;
        o_bundle.sub_sra = 1'b1;
        o_bundle.br      = w_funct3;
        o_bundle.is_br   = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      o_bundle.func    = c_func_add;
      o_bundle.sub_sra = 1'b0;
      o_bundle.illegal = 1'b1;
      o_bundle.we      = 1'b0;
    end else begin
      o_bundle.we = w_we && (w_rd != 5'd0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : Decode-and-issue stage ahead of the RV32I ALU: writeback
//               bypass, combinational decode and a valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
)
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [4:0]      out_shamt,
  output logic            out_sub_sra,
  output logic [3:0]      out_func,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic [2:0]      out_br,
  output logic            out_is_br,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  logic [4:0]  w_rs1_idx;
  logic [4:0]  w_rs2_idx;
  logic [31:0] w_rs1_fwd;
  logic [31:0] w_rs2_fwd;
  logic        w_load;
  ex_bundle_t  w_dec;
  ex_bundle_t  r_bundle;
  logic        r_valid;

  assign w_rs1_idx = in_instr[19:15];
  assign w_rs2_idx = in_instr[24:20];

  // Writeback bypass; x0 is never forwarded since it always reads zero
  assign w_rs1_fwd = (wb_we && (wb_rd != 5'd0) && (wb_rd == w_rs1_idx)) ? wb_data : rs1_data;
  assign w_rs2_fwd = (wb_we && (wb_rd != 5'd0) && (wb_rd == w_rs2_idx)) ? wb_data : rs2_data;

  rv32i_decoder u_decoder (
    .i_instr  (in_instr),
    .i_pc     (in_pc),
    .i_rs1    (w_rs1_fwd),
    .i_rs2    (w_rs2_fwd),
    .o_bundle (w_dec)
  );

  assign in_ready = !r_valid || out_ready;
  assign w_load   = in_valid && in_ready && !flush;

  // Output register: flush beats load, load beats drain, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_bundle <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid  <= 1'b1;
      r_bundle <= w_dec;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_a       = r_bundle.a;
  assign out_b       = r_bundle.b;
  assign out_shamt   = r_bundle.shamt;
  assign out_sub_sra = r_bundle.sub_sra;
  assign out_func    = r_bundle.func;
  assign out_rd      = r_bundle.rd;
  assign out_we      = r_bundle.we;
  assign out_br      = r_bundle.br;
  assign out_is_br   = r_bundle.is_br;
  assign out_pc      = r_bundle.pc;
  assign out_illegal = r_bundle.illegal;

endmodule
`default_nettype wire
